load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Bridges the core's execute stage to the data memory (clk/reset_n, addr, write_data,
//  mem_read, mem_write, byte_enable -> read_data, ready). Takes one RV32I load/store
//  request at a time and word-aligns the address. Builds byte enables and lane-replicated
//  store data, waits for memory ready, then sign/zero-extends the load result. Misaligned
//  accesses, illegal funct3 values and memory timeouts are flagged on resp_err.
// PARAMETERS
//  TIMEOUT   16   max ACCESS cycles waiting for mem_ready before aborting with resp_err
// PORTS
//  clk             in   1   system clock, all state on rising edge
//  reset_n         in   1   asynchronous, active-low reset
//  req_valid       in   1   core presents a request
//  req_ready       out  1   LSU can accept (high only in IDLE)
//  req_we          in   1   1=store, 0=load
//  req_funct3      in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  req_addr        in   32  byte address
//  req_wdata       in   32  store data (low bits significant for B/H)
//  resp_valid      out  1   one-cycle pulse: request complete
//  resp_rdata      out  32  extended load data (0 for stores and errors)
//  resp_err        out  1   misaligned/illegal/timeout; valid with resp_valid
//  mem_addr        out  32  {req_addr[31:2],2'b00}
//  mem_write_data  out  32  lane-replicated store data
//  mem_read        out  1   read strobe, held through ACCESS
//  mem_write       out  1   write strobe, held through ACCESS
//  mem_byte_enable out  4   lane enables
//  mem_read_data   in   32  word from memory
//  mem_ready       in   1   memory done; sampled only in ACCESS
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, mem_addr,
//  mem_write_data = 0; mem_byte_enable = 4'b0000; timeout counter = 0. Reset asserted
//  mid-ACCESS drops the strobes immediately. The pending request is discarded with no response.
//  FSM: IDLE -> ACCESS on req_valid&&req_ready when the request is legal.
//       IDLE -> RESP when the request is illegal; no memory strobe is issued.
//       ACCESS -> RESP at the edge where mem_ready==1; load data is captured then.
//       ACCESS -> RESP with err=1, rdata=0 when the counter reaches TIMEOUT.
//       RESP -> IDLE unconditionally. resp_valid is high for exactly the RESP cycle.
//  Request fields are registered on acceptance. Outputs depend on the registered copy only.
//  Strobes: mem_read=!we and mem_write=we, asserted only in ACCESS.
//  mem_byte_enable is valid in ACCESS and 0 otherwise. Loads drive 4'b1111.
//  Illegal when: H/HU/SH with addr[0]=1; W with addr[1:0]!=0; load funct3 in {011,110,111};
//  store funct3 not in {000,001,010}.
//  Store lanes: SB be=4'b0001<<addr[1:0], data={4{wdata[7:0]}}.
//  SH be=4'b0011<<addr[1:0], data={2{wdata[15:0]}}. SW be=4'b1111, data=wdata.
//  Load extract: sh=mem_read_data>>(8*addr[1:0]).
//  LB sign-extends sh[7:0]. LBU zero-extends sh[7:0].
//  LH sign-extends sh[15:0]. LHU zero-extends sh[15:0]. LW passes the word unchanged.
//  Latency: acceptance edge N -> ACCESS in cycle N+1. Memory ready seen at edge M gives
//  resp_valid in cycle M+1. An illegal request gives resp_valid in cycle N+1.
//  Timeout counter: width $clog2(TIMEOUT+1). Cleared on entering ACCESS, +1 per ACCESS
//  cycle, saturates. If mem_ready and counter==TIMEOUT occur together, mem_ready wins (no error).
//  req_valid during ACCESS/RESP is ignored because req_ready=0. The core holds its request.
// STRUCTURE
//  lsu_pkg: funct3 constants (F3_B,F3_H,F3_W,F3_BU,F3_HU) and state encoding
//  (S_IDLE,S_ACCESS,S_RESP).
//  Sub-module lsu_align (combinational) computes be, wdata and misaligned from funct3/addr,
//  and rdata_ext from funct3/addr/mem_read_data. The top level holds the FSM, request
//  registers and timeout counter.
// TESTING (bench includes the existing memory model as the downstream slave)
//  SW 0x00000008 <- 0xAABBCCDD, then LW 0x8 -> resp_rdata=0xAABBCCDD, err=0
//  SB addr 0x0000000A wdata 0x000000F0 -> be=4'b0100, mem_write_data=0xF0F0F0F0;
//  then LB 0xA -> 0xFFFFFFF0, LBU 0xA -> 0x000000F0
//  SH addr 0x12 wdata 0x8001 -> be=4'b1100; then LH 0x12 -> 0xFFFF8001, LHU -> 0x00008001
//  LW 0x41 and SH 0x13 -> resp_valid one cycle after acceptance, err=1, mem_read/mem_write never high
//  Stub memory holding mem_ready=0 -> resp_err=1 after TIMEOUT=16 ACCESS cycles, strobes drop in RESP
//  reset_n low mid-ACCESS -> strobes 0 immediately, no resp_valid; next request after release completes

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit.
// Holds the funct3 encodings, the FSM states and the funct3 legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  function automatic logic f3_illegal(
    input logic       we,
    input logic [2:0] f3
  );
    if (we)
      return !(f3 inside {F3_B, F3_H, F3_W});
    else
      return f3 inside {3'b011, 3'b110, 3'b111};
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU.
// Produces store enables/data, the misalignment flag and the extended load data.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic        misaligned,
  output logic [31:0] rdata_ext
);

  logic        is_b;
  logic        is_h;
  logic        is_w;
  logic [31:0] sh;

  assign is_b = (funct3 == F3_B) || (funct3 == F3_BU);
  assign is_h = (funct3 == F3_H) || (funct3 == F3_HU);
  assign is_w = (funct3 == F3_W);
  assign sh   = mem_rdata >> {addr_lo, 3'b000};

  always_comb begin
    be         = 4'b0000;
    st_data    = 32'h0;
    misaligned = 1'b0;
    unique case (1'b1)
      is_b: begin
        be      = 4'b0001 << addr_lo;
        st_data = {4{wdata[7:0]}};
      end
      is_h: begin
        be         = 4'b0011 << addr_lo;
        st_data    = {2{wdata[15:0]}};
        misaligned = addr_lo[0];
      end
      is_w: begin
        be         = 4'b1111;
        st_data    = wdata;
        misaligned = |addr_lo;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (funct3)
      F3_B:    rdata_ext = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   rdata_ext = {24'h0, sh[7:0]};
      F3_H:    rdata_ext = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   rdata_ext = {16'h0, sh[15:0]};
      default: rdata_ext = mem_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time between execute and data memory.
// Single FSM with registered memory strobes, lane enables and response.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  input  logic [31:0] mem_read_data,
  input  logic        mem_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t      state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [1:0]  r_lo;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic        idle;
  logic [2:0]  a_f3;
  logic [1:0]  a_lo;
  logic [3:0]  a_be;
  logic [31:0] a_st;
  logic        a_mis;
  logic [31:0] a_ext;
  logic        bad;

  assign idle      = (state == S_IDLE);
  assign req_ready = idle;

  // Decode the incoming request while idle, the held one otherwise.
  assign a_f3 = idle ? req_funct3    : r_f3;
  assign a_lo = idle ? req_addr[1:0] : r_lo;

  lsu_align u_align (
    .funct3     (a_f3),
    .addr_lo    (a_lo),
    .wdata      (req_wdata),
    .mem_rdata  (mem_read_data),
    .be         (a_be),
    .st_data    (a_st),
    .misaligned (a_mis),
    .rdata_ext  (a_ext)
  );

  assign bad = a_mis | f3_illegal(req_we, req_funct3);

  assign cnt_nxt = (cnt == CW'(TIMEOUT)) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      r_we            <= 1'b0;
      r_f3            <= 3'b000;
      r_lo            <= 2'b00;
      cnt             <= '0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0;
      resp_err        <= 1'b0;
      mem_addr        <= 32'h0;
      mem_write_data  <= 32'h0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_byte_enable <= 4'b0000;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_f3     <= req_funct3;
            r_lo     <= req_addr[1:0];
            mem_addr <= {req_addr[31:2], 2'b00};
            if (bad) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'h0;
            end else begin
              state           <= S_ACCESS;
              cnt             <= '0;
              mem_read        <= !req_we;
              mem_write       <= req_we;
              mem_byte_enable <= req_we ? a_be : 4'b1111;
              mem_write_data  <= req_we ? a_st : 32'h0;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready || cnt_nxt == CW'(TIMEOUT)) begin
            state           <= S_RESP;
            resp_valid      <= 1'b1;
            resp_err        <= !mem_ready;
            resp_rdata      <= (mem_ready && !r_we) ? a_ext : 32'h0;
            mem_read        <= 1'b0;
            mem_write       <= 1'b0;
            mem_byte_enable <= 4'b0000;
          end
          cnt <= cnt_nxt;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a byte-enable memory model.
// Expected responses are queued at issue and popped on resp_valid.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_read_data;
  logic        mem_ready;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_addr        (mem_addr),
    .mem_write_data  (mem_write_data),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_read_data   (mem_read_data),
    .mem_ready       (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory model: ready one cycle after a wait, writes land on the ready edge.
  logic [31:0] mem [0:63];
  logic        stall = 1'b0;
  int          wait_cnt;

  assign mem_read_data = mem[mem_addr[7:2]];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_ready <= 1'b0;
      wait_cnt  <= 0;
    end else if ((mem_read || mem_write) && !mem_ready && !stall) begin
      if (wait_cnt == 1) begin
        mem_ready <= 1'b1;
        wait_cnt  <= 0;
        if (mem_write)
          for (int i = 0; i < 4; i++)
            if (mem_byte_enable[i])
              mem[mem_addr[7:2]][8*i +: 8] <= mem_write_data[8*i +: 8];
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      mem_ready <= 1'b0;
      wait_cnt  <= 0;
    end
  end

  logic [32:0] sb [$];
  int          cyc = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          resp_cyc = 0;
  logic [3:0]  last_be = 4'h0;
  logic [31:0] last_wd = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [32:0] e;
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt  <= wr_cnt + 1;
      last_be <= mem_byte_enable;
      last_wd <= mem_write_data;
    end
    if (resp_valid) begin
      resp_cyc <= cyc;
      chk("strobe_in_resp", {30'h0, mem_read, mem_write}, 32'h0);
      if (sb.size() == 0) begin
        chk("unexpected_resp", {31'h0, resp_valid}, 32'h0);
      end else begin
        e = sb.pop_front();
        chk("rdata", resp_rdata, e[31:0]);
        chk("err", {31'h0, resp_err}, {31'h0, e[32]});
      end
    end
  end

  int acc_cyc;

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
    int n;
    sb.push_back({exp_err, exp_rd});
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("resp_pending", sb.size(), 0);
      sb.delete();
    end
  endtask

  int rd0;
  int wr0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_strobes", {29'h0, resp_valid, mem_read, mem_write}, 32'h0);
    chk("rst_be", {28'h0, mem_byte_enable}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    reset_n = 1'b1;

    do_req(1, F3_W, 32'h8, 32'hAABBCCDD, 32'h0, 0);
    chk("sw_be", {28'h0, last_be}, 32'hF);
    chk("sw_wd", last_wd, 32'hAABBCCDD);
    do_req(0, F3_W, 32'h8, 32'h0, 32'hAABBCCDD, 0);

    do_req(1, F3_B, 32'hA, 32'h000000F0, 32'h0, 0);
    chk("sb_be", {28'h0, last_be}, 32'h4);
    chk("sb_wd", last_wd, 32'hF0F0F0F0);
    do_req(0, F3_B, 32'hA, 32'h0, 32'hFFFFFFF0, 0);
    do_req(0, F3_BU, 32'hA, 32'h0, 32'h000000F0, 0);

    do_req(1, F3_H, 32'h12, 32'h00008001, 32'h0, 0);
    chk("sh_be", {28'h0, last_be}, 32'hC);
    chk("sh_wd", last_wd, 32'h80018001);
    do_req(0, F3_H, 32'h12, 32'h0, 32'hFFFF8001, 0);
    do_req(0, F3_HU, 32'h12, 32'h0, 32'h00008001, 0);

    do_req(0, F3_B, 32'h8, 32'h0, 32'hFFFFFFDD, 0);
    do_req(0, F3_B, 32'hB, 32'h0, 32'hFFFFFFAA, 0);
    do_req(0, F3_H, 32'hA, 32'h0, 32'hFFFFAAF0, 0);
    do_req(0, F3_HU, 32'h8, 32'h0, 32'h0000CCDD, 0);

    rd0 = rd_cnt;
    wr0 = wr_cnt;
    do_req(0, F3_W, 32'h41, 32'h0, 32'h0, 1);
    chk("lw_mis_lat", resp_cyc - acc_cyc, 0);
    do_req(1, F3_H, 32'h13, 32'h1234, 32'h0, 1);
    chk("sh_mis_lat", resp_cyc - acc_cyc, 0);
    do_req(0, 3'b011, 32'h0, 32'h0, 32'h0, 1);
    do_req(1, F3_BU, 32'h0, 32'h55, 32'h0, 1);
    chk("illegal_rd", rd_cnt - rd0, 0);
    chk("illegal_wr", wr_cnt - wr0, 0);

    stall = 1'b1;
    rd0 = rd_cnt;
    do_req(0, F3_W, 32'h20, 32'h0, 32'h0, 1);
    chk("timeout_cycles", rd_cnt - rd0, 16);

    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h8;
    req_wdata  = 32'h11111111;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("wr_before_rst", {31'h0, mem_write}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    stall   = 1'b0;
    do_req(0, F3_W, 32'h8, 32'h0, 32'hAAF0CCDD, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
